ftab_lookup_responder: RTL and testbench
========================================

// Module: ftab_lookup_responder
// PURPOSE
//  Responder end of the ftabind/ftabval table-lookup stream pair used by the JPEG symbol decoder.
//  Accepts index tokens on ftabind, reads a loadable DEPTH-entry table, returns one value token per index on ftabval.
//  Returns values in request order and forwards end-of-stream tokens.
//  Sits beside the decoder page; the table is filled through a separate write port before or during decode.
// PARAMETERS
//  IW      8    index width (ftabind_d, ld_addr)
//  DW      8    value width (ftabval_d, ld_data)
//  DEPTH   256  table entries; must equal 2**IW
//  QDEPTH  2    output queue depth; legal values 2..8
// PORTS
//  clock       in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  ftabind_d   in   IW  lookup index
//  ftabind_e   in   1   end-of-stream flag; index ignored when 1
//  ftabind_v   in   1   index token valid
//  ftabind_b   out  1   back-pressure; 1 = responder cannot accept
//  ftabval_d   out  DW  table value
//  ftabval_e   out  1   end-of-stream flag
//  ftabval_v   out  1   value token valid
//  ftabval_b   in   1   back-pressure from consumer
//  ld_we       in   1   table write enable
//  ld_addr     in   IW  table write address
//  ld_data     in   DW  table write data
// BEHAVIOUR
//  Transfer rules:
//   - Input transfer occurs when ftabind_v=1 and ftabind_b=0 at the clock edge.
//   - Output transfer occurs when ftabval_v=1 and ftabval_b=0 at the clock edge.
//  Reset, asserted asynchronously:
//   - Queue count=0, in-flight stage empty.
//   - ftabval_v=0, ftabval_e=0, ftabval_d=0; ftabind_b=0.
//   - Table contents are not reset.
//  Pipeline:
//   - Stage 1: synchronous table read, registered as in-flight token {d, e, valid}.
//   - Stage 2: output FIFO of QDEPTH entries. Head drives ftabval_* from registers.
//   - Latency: input transfer at edge N -> ftabval_v=1 after edge N+2 when the queue was empty.
//   - Throughput: 1 token/cycle while ftabval_b=0.
//  Back-pressure:
//   - ftabind_b = (count + inflight) >= QDEPTH.
//   - Combinational from registered state only. Never depends on ftabind_v or on ftabval_b in the same cycle.
//   - Conservative: a pop in the current cycle does not free a slot until the next cycle.
//  EOS tokens:
//   - ftabind_e=1 produces an output token with ftabval_e=1 and ftabval_d=0; no table read is used.
//   - EOS keeps its order relative to value tokens.
//   - Tokens after EOS are accepted normally (next stream).
//  Simultaneous events:
//   - Push from stage 1 and pop in the same cycle: count unchanged, FIFO order preserved.
//   - Write and read to the same address in one cycle: the read returns OLD data (read-first).
//   - Writes are allowed every cycle, independent of the streams.
//  Boundaries:
//   - count never exceeds QDEPTH. Overflow is impossible by the ftabind_b rule; bench asserts it.
//   - Pointers wrap modulo QDEPTH.
//   - ftabval_d/e hold stable while ftabval_v=1 and ftabval_b=1.
//  Reset mid-operation: all queued and in-flight tokens are discarded; no partial token is emitted after reset.
// TESTING
//  1. Load table[i]=i^8'hA5 for all i; send indices 0,1,255 with ftabval_b=0 -> ftabval_d A5,A4,5A in order, first valid 2 cycles after accept.
//  2. Hold ftabval_b=1 and drive ftabind_v=1 continuously -> exactly QDEPTH tokens accepted, ftabind_b=1 thereafter. Release -> drain in order, no loss or duplicate.
//  3. Send idx 3, EOS, idx 4 -> outputs {table[3],e=0}, {0,e=1}, {table[4],e=0}.
//  4. ld_we=1 to addr 7 with data 8'h3C in the same cycle as an accepted read of idx 7 -> old value returned; the next read of 7 -> 3C.
//  5. Random ftabval_b (50%) over 1000 tokens against a reference model -> identical sequence, count<=QDEPTH always.
//  6. Assert reset with 2 tokens queued -> ftabval_v=0 immediately; after release ftabind_b=0 and no stale token appears.

Source files
------------

// File: rtl/ftab_lookup_responder.sv
// Responder for the ftabind/ftabval table-lookup stream pair: loadable table,
// two in-flight register stages, and a small output FIFO that preserves request order.
module ftab_lookup_responder #(
  parameter int IW     = 8,
  parameter int DW     = 8,
  parameter int DEPTH  = 256,
  parameter int QDEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] ftabind_d,
  input  logic          ftabind_e,
  input  logic          ftabind_v,
  output logic          ftabind_b,
  output logic [DW-1:0] ftabval_d,
  output logic          ftabval_e,
  output logic          ftabval_v,
  input  logic          ftabval_b,
  input  logic          ld_we,
  input  logic [IW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 3);

  logic [DW-1:0] table_mem [DEPTH];

  // Stage 1: registered table read; stage 2: in-flight token awaiting FIFO push.
  logic [DW-1:0] rd_d;
  logic          rd_e;
  logic          rd_v;
  logic [DW-1:0] fly_d;
  logic          fly_e;
  logic          fly_v;

  logic [DW-1:0] q_d [QDEPTH];
  logic [QDEPTH-1:0] q_e;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic accept;
  logic push;
  logic pop;

  // Conservative back-pressure: only registered occupancy is considered.
  assign ftabind_b = (count + CW'(rd_v) + CW'(fly_v)) >= CW'(QDEPTH);
  assign accept    = ftabind_v & ~ftabind_b;
  assign push      = fly_v;
  assign ftabval_v = (count != '0);
  assign pop       = ftabval_v & ~ftabval_b;
  assign ftabval_d = ftabval_v ? q_d[rd_ptr] : '0;
  assign ftabval_e = ftabval_v & q_e[rd_ptr];

  // NOTE: storage arrays carry no reset; validity lives in the reset-controlled
  // flags and counters, and the nonblocking write makes a same-cycle read return old data.
  always_ff @(posedge clock) begin
    if (ld_we) table_mem[ld_addr] <= ld_data;
    if (accept) rd_d <= table_mem[ftabind_d];
    if (push) begin
      q_d[wr_ptr] <= fly_d;
      q_e[wr_ptr] <= fly_e;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_v   <= 1'b0;
      rd_e   <= 1'b0;
      fly_v  <= 1'b0;
      fly_e  <= 1'b0;
      fly_d  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rd_v  <= accept;
      if (accept) rd_e <= ftabind_e;
      fly_v <= rd_v;
      fly_e <= rd_e;
      // End-of-stream tokens carry zero data regardless of what the table read returned.
      fly_d <= rd_e ? '0 : rd_d;
      if (push) wr_ptr <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_ftab_lookup_responder.sv
// Self-checking bench for ftab_lookup_responder: directed vector table, scoreboarded
// random traffic, back-pressure fill/drain and mid-operation reset.
module tb_ftab_lookup_responder;

  localparam int IW     = 8;
  localparam int DW     = 8;
  localparam int DEPTH  = 256;
  localparam int QDEPTH = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [IW-1:0] ftabind_d;
  logic          ftabind_e;
  logic          ftabind_v;
  logic          ftabind_b;
  logic [DW-1:0] ftabval_d;
  logic          ftabval_e;
  logic          ftabval_v;
  logic          ftabval_b;
  logic          ld_we;
  logic [IW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  ftab_lookup_responder #(.IW(IW), .DW(DW), .DEPTH(DEPTH), .QDEPTH(QDEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .ftabind_d (ftabind_d),
    .ftabind_e (ftabind_e),
    .ftabind_v (ftabind_v),
    .ftabind_b (ftabind_b),
    .ftabval_d (ftabval_d),
    .ftabval_e (ftabval_e),
    .ftabval_v (ftabval_v),
    .ftabval_b (ftabval_b),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [IW-1:0] idx;
    logic          e;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_d;
    logic          exp_e;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } tok_t;

  int errors = 0;
  int checks = 0;

  // Reference model: table contents plus an ordered list of owed tokens.
  logic [DW-1:0] model_tab [DEPTH];
  tok_t          exp_q [$];
  int            outstanding = 0;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle while inputs and outputs are stable.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_e;
  always @(negedge clock) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      check("bp_rule", 32'(ftabind_b), 32'(outstanding >= QDEPTH));
      check("occupancy", 32'(outstanding <= QDEPTH), 32'd1);
      if (prev_hold) begin
        check("hold_v", 32'(ftabval_v), 32'd1);
        check("hold_d", 32'(ftabval_d), 32'(prev_d));
        check("hold_e", 32'(ftabval_e), 32'(prev_e));
      end
      if (ftabval_v) begin
        if (exp_q.size() == 0) begin
          check("spurious_token", 32'(ftabval_v), 32'd0);
        end else begin
          check("sb_d", 32'(ftabval_d), 32'(exp_q[0].d));
          check("sb_e", 32'(ftabval_e), 32'(exp_q[0].e));
          if (!ftabval_b) begin
            void'(exp_q.pop_front());
            outstanding--;
          end
        end
      end
      prev_hold = ftabval_v && ftabval_b;
      prev_d    = ftabval_d;
      prev_e    = ftabval_e;
      if (ftabind_v && !ftabind_b) begin
        tok_t t;
        t.e = ftabind_e;
        t.d = ftabind_e ? '0 : model_tab[ftabind_d];
        exp_q.push_back(t);
        outstanding++;
      end
      // Table update after the lookup: a same-cycle read sees old contents.
      if (ld_we) model_tab[ld_addr] = ld_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int got;
    int sent;
    int cyc;

    vecs[0] = '{idx: 8'd0,   e: 1'b0, we: 1'b0, wdata: 8'h00, exp_d: 8'hA5, exp_e: 1'b0};
    vecs[1] = '{idx: 8'd1,   e: 1'b0, we: 1'b0, wdata: 8'h00, exp_d: 8'hA4, exp_e: 1'b0};
    vecs[2] = '{idx: 8'd255, e: 1'b0, we: 1'b0, wdata: 8'h00, exp_d: 8'h5A, exp_e: 1'b0};
    vecs[3] = '{idx: 8'd3,   e: 1'b0, we: 1'b0, wdata: 8'h00, exp_d: 8'hA6, exp_e: 1'b0};
    vecs[4] = '{idx: 8'd9,   e: 1'b1, we: 1'b0, wdata: 8'h00, exp_d: 8'h00, exp_e: 1'b1};
    vecs[5] = '{idx: 8'd4,   e: 1'b0, we: 1'b0, wdata: 8'h00, exp_d: 8'hA1, exp_e: 1'b0};
    vecs[6] = '{idx: 8'd7,   e: 1'b0, we: 1'b1, wdata: 8'h3C, exp_d: 8'hA2, exp_e: 1'b0};
    vecs[7] = '{idx: 8'd7,   e: 1'b0, we: 1'b0, wdata: 8'h00, exp_d: 8'h3C, exp_e: 1'b0};

    reset     = 1'b1;
    ftabind_d = '0;
    ftabind_e = 1'b0;
    ftabind_v = 1'b0;
    ftabval_b = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    tick();
    tick();
    check("rst_v", 32'(ftabval_v), 32'd0);
    check("rst_e", 32'(ftabval_e), 32'd0);
    check("rst_d", 32'(ftabval_d), 32'd0);
    check("rst_bp", 32'(ftabind_b), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      ld_we   = 1'b1;
      ld_addr = IW'(i);
      ld_data = DW'(i) ^ 8'hA5;
      tick();
    end
    ld_we = 1'b0;
    tick();

    // Directed vectors, one token at a time, checking the two-edge latency.
    for (int i = 0; i < 8; i++) begin
      ftabind_v = 1'b1;
      ftabind_d = vecs[i].idx;
      ftabind_e = vecs[i].e;
      ld_we     = vecs[i].we;
      ld_addr   = vecs[i].idx;
      ld_data   = vecs[i].wdata;
      check("vec_idle_bp", 32'(ftabind_b), 32'd0);
      tick();
      ftabind_v = 1'b0;
      ftabind_e = 1'b0;
      ld_we     = 1'b0;
      check("vec_lat_n", 32'(ftabval_v), 32'd0);
      tick();
      check("vec_lat_n1", 32'(ftabval_v), 32'd0);
      tick();
      check("vec_v", 32'(ftabval_v), 32'd1);
      check("vec_d", 32'(ftabval_d), 32'(vecs[i].exp_d));
      check("vec_e", 32'(ftabval_e), 32'(vecs[i].exp_e));
      tick();
      check("vec_popped", 32'(ftabval_v), 32'd0);
    end

    // Back-pressure fill: consumer stalled, producer always valid.
    ftabval_b = 1'b1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      ftabind_v = 1'b1;
      ftabind_e = 1'b0;
      ftabind_d = IW'(16 + acc);
      if (!ftabind_b) acc++;
      tick();
    end
    ftabind_v = 1'b0;
    check("fill_count", 32'(acc), 32'(QDEPTH));
    check("fill_bp", 32'(ftabind_b), 32'd1);
    ftabval_b = 1'b0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (ftabval_v) begin
        check("drain_d", 32'(ftabval_d), 32'((DW'(16 + got)) ^ 8'hA5));
        got++;
      end
      tick();
    end
    check("drain_count", 32'(got), 32'(QDEPTH));

    // Random traffic with 50% consumer stall and background table writes.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      ftabval_b = 1'($urandom_range(0, 1));
      ftabind_v = ($urandom_range(0, 3) != 0);
      ftabind_d = IW'($urandom);
      ftabind_e = ($urandom_range(0, 15) == 0);
      ld_we     = ($urandom_range(0, 7) == 0);
      ld_addr   = IW'($urandom);
      ld_data   = DW'($urandom);
      if (ftabind_v && !ftabind_b) sent++;
      tick();
      cyc++;
    end
    ftabind_v = 1'b0;
    ftabind_e = 1'b0;
    ld_we     = 1'b0;
    ftabval_b = 1'b0;
    check("rand_sent", 32'(sent), 32'd1000);
    for (int c = 0; c < 20; c++) tick();
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_idle_v", 32'(ftabval_v), 32'd0);

    // Reset with tokens queued.
    ftabval_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ftabind_v = 1'b1;
      ftabind_d = IW'(40 + i);
      tick();
    end
    ftabind_v = 1'b0;
    tick();
    tick();
    tick();
    check("prereset_v", 32'(ftabval_v), 32'd1);
    check("prereset_bp", 32'(ftabind_b), 32'd1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    outstanding = 0;
    #1;
    check("async_rst_v", 32'(ftabval_v), 32'd0);
    check("async_rst_bp", 32'(ftabind_b), 32'd0);
    tick();
    reset     = 1'b0;
    ftabval_b = 1'b0;
    check("postreset_bp", 32'(ftabind_b), 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("postreset_v", 32'(ftabval_v), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
